// File: rtl/eth_txgen_pkg.sv
// Shared types and constants for the multi-channel Ethernet test-frame generator.
package eth_txgen_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR  = 3'd1,
      SEQ  = 3'd2,
      PAY  = 3'd3,
      GAP  = 3'd4
   } state_e;

   localparam int unsigned HDR_LEN = 14;
   localparam int unsigned SEQ_LEN = 4;
   localparam int unsigned MIN_PAY = 46;
   localparam int unsigned MAX_PAY = 1500;

   function automatic logic [10:0] clamp_len(input logic [15:0] len);
      logic [10:0] res;
      if (len < 16'(MIN_PAY)) begin
         res = 11'(MIN_PAY);
      end else if (len > 16'(MAX_PAY)) begin
         res = 11'(MAX_PAY);
      end else begin
         res = len[10:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/eth_txgen_ch.sv
// One generator channel: frame FSM, byte position, gap counter, sequence number and
// the registered AXI-Stream output stage.
module eth_txgen_ch
   import eth_txgen_pkg::*;
#(
   parameter int LEN_W = 11,
   parameter int GAP_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             abort,
   input  logic [LEN_W-1:0] frame_len,
   input  logic [GAP_W-1:0] gap,
   input  logic [47:0]      dst_mac,
   input  logic [47:0]      src_mac,
   input  logic [15:0]      ethertype,
   input  logic             mode,
   input  logic [7:0]       pat,
   output logic [7:0]       tx_tdata,
   output logic             tx_tvalid,
   output logic             tx_tlast,
   output logic             tx_tuser,
   input  logic             tx_tready,
   output logic [31:0]      frm_cnt,
   output logic             busy
);

   state_e           state_q, state_d;
   logic [10:0]      pos_q, pos_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [31:0]      seq_q, seq_d;
   logic [10:0]      len_q, len_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             mode_q, mode_d;
   logic [7:0]       pat_q, pat_d;
   logic [47:0]      dst_q, dst_d;
   logic [47:0]      src_q, src_d;
   logic [15:0]      type_q, type_d;
   logic [7:0]       tdata_q, tdata_d;
   logic             tvalid_q, tvalid_d;
   logic             tlast_q, tlast_d;
   logic             tuser_q, tuser_d;
   logic             busy_q, busy_d;

   logic             hs;
   logic [10:0]      pos_nxt;
   logic [10:0]      last_pos;
   logic [143:0]     hdr_vec;
   logic [7:0]       bit_off;
   logic [7:0]       hdr_byte;
   logic [7:0]       pay_k;
   logic [7:0]       nxt_byte;
   state_e           seg;

   // Next-state, next-byte and output-register computation.
   always_comb begin
      hs       = tvalid_q & tx_tready;
      pos_nxt  = pos_q + 11'd1;
      last_pos = len_q + 11'(HDR_LEN - 1);
      hdr_vec  = {dst_q, src_q, type_q, seq_q};
      bit_off  = {pos_nxt[4:0], 3'b000};
      hdr_byte = hdr_vec[8'd143 - bit_off -: 8];
      pay_k    = pos_nxt[7:0] - 8'(HDR_LEN + SEQ_LEN);
      if (pos_nxt < 11'(HDR_LEN + SEQ_LEN)) begin
         nxt_byte = hdr_byte;
      end else begin
         nxt_byte = mode_q ? pat_q : pay_k;
      end
      if (pos_nxt < 11'(HDR_LEN)) begin
         seg = HDR;
      end else if (pos_nxt < 11'(HDR_LEN + SEQ_LEN)) begin
         seg = SEQ;
      end else begin
         seg = PAY;
      end

      state_d   = state_q;
      pos_d     = pos_q;
      gap_cnt_d = gap_cnt_q;
      seq_d     = seq_q;
      len_d     = len_q;
      gap_d     = gap_q;
      mode_d    = mode_q;
      pat_d     = pat_q;
      dst_d     = dst_q;
      src_d     = src_q;
      type_d    = type_q;
      tdata_d   = tdata_q;
      tvalid_d  = tvalid_q;
      tlast_d   = tlast_q;
      tuser_d   = tuser_q;

      case (state_q)
         IDLE: begin
            if (en) begin
               state_d  = HDR;
               pos_d    = 11'd0;
               len_d    = clamp_len(16'(frame_len));
               gap_d    = gap;
               mode_d   = mode;
               pat_d    = pat;
               dst_d    = dst_mac;
               src_d    = src_mac;
               type_d   = ethertype;
               tdata_d  = dst_mac[47:40];
               tvalid_d = 1'b1;
               tlast_d  = 1'b0;
               tuser_d  = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         HDR, SEQ, PAY: begin
            if (hs && tlast_q) begin
               tvalid_d = 1'b0;
               tlast_d  = 1'b0;
               tuser_d  = 1'b0;
               tdata_d  = 8'h00;
               // An aborted frame does not consume a sequence number.
               if (tuser_q) begin
                  seq_d = seq_q;
               end else begin
                  seq_d = seq_q + 32'd1;
               end
               if (gap_q == {GAP_W{1'b0}}) begin
                  state_d = IDLE;
               end else begin
                  state_d   = GAP;
                  gap_cnt_d = gap_q;
               end
            end else if (hs) begin
               state_d = seg;
               pos_d   = pos_nxt;
               tdata_d = nxt_byte;
               tlast_d = abort | (pos_nxt == last_pos);
               tuser_d = abort;
            end else if (abort) begin
               tlast_d = 1'b1;
               tuser_d = 1'b1;
            end else begin
               tvalid_d = 1'b1;
            end
         end
         GAP: begin
            if (gap_cnt_q <= GAP_W'(1)) begin
               state_d   = IDLE;
               gap_cnt_d = {GAP_W{1'b0}};
            end else begin
               gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pos_q     <= 11'd0;
         gap_cnt_q <= {GAP_W{1'b0}};
         seq_q     <= 32'd0;
         len_q     <= 11'd0;
         gap_q     <= {GAP_W{1'b0}};
         mode_q    <= 1'b0;
         pat_q     <= 8'h00;
         dst_q     <= 48'h0;
         src_q     <= 48'h0;
         type_q    <= 16'h0;
         tdata_q   <= 8'h00;
         tvalid_q  <= 1'b0;
         tlast_q   <= 1'b0;
         tuser_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pos_q     <= pos_d;
         gap_cnt_q <= gap_cnt_d;
         seq_q     <= seq_d;
         len_q     <= len_d;
         gap_q     <= gap_d;
         mode_q    <= mode_d;
         pat_q     <= pat_d;
         dst_q     <= dst_d;
         src_q     <= src_d;
         type_q    <= type_d;
         tdata_q   <= tdata_d;
         tvalid_q  <= tvalid_d;
         tlast_q   <= tlast_d;
         tuser_q   <= tuser_d;
         busy_q    <= busy_d;
      end
   end

   assign tx_tdata  = tdata_q;
   assign tx_tvalid = tvalid_q;
   assign tx_tlast  = tlast_q;
   assign tx_tuser  = tuser_q;
   assign frm_cnt   = seq_q;
   assign busy      = busy_q;

endmodule

// File: rtl/eth_txgen.sv
// Ethernet test-frame generator: ETHCOUNT independent channels sharing one
// configuration, each feeding its own 8-bit AXI-Stream MAC transmit port.
module eth_txgen
   import eth_txgen_pkg::*;
#(
   parameter int ETHCOUNT = 1,
   parameter int LEN_W    = 11,
   parameter int GAP_W    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ETHCOUNT-1:0]   en,
   input  logic [ETHCOUNT-1:0]   abort,
   input  logic [LEN_W-1:0]      frame_len,
   input  logic [GAP_W-1:0]      gap,
   input  logic [47:0]           dst_mac,
   input  logic [47:0]           src_mac,
   input  logic [15:0]           ethertype,
   input  logic                  mode,
   input  logic [7:0]            pat,
   output logic [ETHCOUNT*8-1:0] tx_tdata,
   output logic [ETHCOUNT-1:0]   tx_tvalid,
   output logic [ETHCOUNT-1:0]   tx_tlast,
   output logic [ETHCOUNT-1:0]   tx_tuser,
   input  logic [ETHCOUNT-1:0]   tx_tready,
   output logic [ETHCOUNT*32-1:0] frm_cnt,
   output logic [ETHCOUNT-1:0]   busy
);

   for (genvar x = 0; x < ETHCOUNT; x++) begin : g_ch
      eth_txgen_ch #(
         .LEN_W (LEN_W),
         .GAP_W (GAP_W)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .en        (en[x]),
         .abort     (abort[x]),
         .frame_len (frame_len),
         .gap       (gap),
         .dst_mac   (dst_mac),
         .src_mac   (src_mac),
         .ethertype (ethertype),
         .mode      (mode),
         .pat       (pat),
         .tx_tdata  (tx_tdata[x*8 +: 8]),
         .tx_tvalid (tx_tvalid[x]),
         .tx_tlast  (tx_tlast[x]),
         .tx_tuser  (tx_tuser[x]),
         .tx_tready (tx_tready[x]),
         .frm_cnt   (frm_cnt[x*32 +: 32]),
         .busy      (busy[x])
      );
   end

endmodule

// File: tb/tb_eth_txgen.sv
// Scoreboard bench for eth_txgen: a byte-level frame model fills per-channel
// queues, a negedge monitor pops and compares every handshaked byte.
module tb_eth_txgen;
   localparam int N = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   en, abort, tready;
   logic [10:0]    frame_len;
   logic [15:0]    gap;
   logic [47:0]    dst_mac, src_mac;
   logic [15:0]    ethertype;
   logic           mode;
   logic [7:0]     pat;
   logic [N*8-1:0] tx_tdata;
   logic [N-1:0]   tx_tvalid, tx_tlast, tx_tuser, busy;
   logic [N*32-1:0] frm_cnt;

   always #5 clk = ~clk;

   eth_txgen #(.ETHCOUNT(N), .LEN_W(11), .GAP_W(16)) dut (
      .clk(clk), .rst(rst), .en(en), .abort(abort), .frame_len(frame_len), .gap(gap),
      .dst_mac(dst_mac), .src_mac(src_mac), .ethertype(ethertype), .mode(mode), .pat(pat),
      .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tlast(tx_tlast), .tx_tuser(tx_tuser),
      .tx_tready(tready), .frm_cnt(frm_cnt), .busy(busy)
   );

   int          errors = 0;
   int          checks = 0;
   logic [9:0]  exp_q0[$];
   logic [9:0]  exp_q1[$];
   int          frames_started[N];
   int          frames_done[N];
   int          bytes_seen[N];
   int          low_run[N];
   logic [31:0] model_seq[N];
   logic [9:0]  prev_out[N];
   logic [N-1:0] prev_stall, prev_abort, in_frame, low_valid;
   int          stall_at = 1 << 30;
   int          rdy_pct = 100;
   bit          gap_chk = 1'b0;
   int          exp_low = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference frame: {tlast, tuser, data} per byte; abort_at >= 0 truncates there.
   task automatic push_frame(input int ch, input logic [31:0] seq, input int abort_at);
      int L, total;
      logic [7:0] d;
      logic [9:0] b;
      L = int'(frame_len);
      if (L < 46) L = 46;
      if (L > 1500) L = 1500;
      total = 14 + L;
      for (int i = 0; i < total; i++) begin
         if (i < 6)       d = 8'(dst_mac >> (8 * (5 - i)));
         else if (i < 12) d = 8'(src_mac >> (8 * (11 - i)));
         else if (i < 14) d = 8'(ethertype >> (8 * (13 - i)));
         else if (i < 18) d = 8'(seq >> (8 * (17 - i)));
         else             d = mode ? pat : 8'((i - 18) % 256);
         if (i == abort_at) b = {1'b1, 1'b1, d};
         else               b = {(i == total - 1), 1'b0, d};
         if (ch == 0) exp_q0.push_back(b);
         else         exp_q1.push_back(b);
         if (i == abort_at) break;
      end
   endtask

   task automatic rand_cfg();
      frame_len = 11'($urandom_range(0, 200));
      gap       = 16'($urandom_range(0, 20));
      mode      = 1'($urandom_range(0, 1));
      pat       = 8'($urandom);
      dst_mac   = 48'({$urandom, $urandom});
      src_mac   = 48'({$urandom, $urandom});
      ethertype = 16'($urandom);
   endtask

   task automatic wait_cond_timeout(input string name, input int cyc);
      if (cyc >= 20000) begin
         checks++;
         errors++;
         $display("FAIL timeout %s at %0t", name, $time);
      end
   endtask

   // Runs n frames on ch, dropping en once the last one is 3 bytes in, then
   // scrambles the shared config mid-frame (must not affect the latched frame).
   task automatic run_frames(input int ch, input int n);
      int s0, d0, cyc;
      s0 = frames_started[ch];
      d0 = frames_done[ch];
      cyc = 0;
      en[ch] = 1'b1;
      while (!(frames_started[ch] >= s0 + n && bytes_seen[ch] >= 3) && cyc < 20000) begin
         @(posedge clk); #1; cyc++;
      end
      en[ch] = 1'b0;
      rand_cfg();
      while (frames_done[ch] < d0 + n && cyc < 20000) begin
         @(posedge clk); #1; cyc++;
      end
      wait_cond_timeout("run_frames", cyc);
   endtask

   task automatic settle(input int ch);
      repeat (60) @(posedge clk);
      #1;
      check("idle_tvalid", tx_tvalid[ch], 1'b0);
      check("idle_busy", busy[ch], 1'b0);
      check("frm_cnt", frm_cnt[ch*32 +: 32], model_seq[ch]);
      check("queue_left", (ch == 0) ? exp_q0.size() : exp_q1.size(), 0);
   endtask

   task automatic do_frames(input int ch, input int n);
      for (int i = 0; i < n; i++) push_frame(ch, model_seq[ch] + 32'(i), -1);
      model_seq[ch] = model_seq[ch] + 32'(n);
      run_frames(ch, n);
      settle(ch);
   endtask

   // tready generator: random duty, with a forced stall on ch0 past stall_at bytes.
   initial begin
      tready = '0;
      forever begin
         @(posedge clk); #1;
         for (int c = 0; c < N; c++) begin
            if (c == 0 && bytes_seen[0] >= stall_at) tready[c] = 1'b0;
            else tready[c] = (int'($urandom_range(0, 99)) < rdy_pct);
         end
      end
   end

   // Monitor: handshake scoreboard, hold-while-stalled, no mid-frame drop, gap length.
   always @(negedge clk) begin
      logic [9:0] cur, exp_b;
      for (int ch = 0; ch < N; ch++) begin
         cur = {tx_tlast[ch], tx_tuser[ch], tx_tdata[ch*8 +: 8]};
         if (rst) begin
            in_frame[ch]   = 1'b0;
            prev_stall[ch] = 1'b0;
            low_valid[ch]  = 1'b0;
         end else begin
            if (prev_stall[ch] && !prev_abort[ch]) check("hold_stable", cur, prev_out[ch]);
            if (in_frame[ch] && !tx_tvalid[ch]) check("tvalid_drop", tx_tvalid[ch], 1'b1);
            if (tx_tvalid[ch] && !in_frame[ch]) begin
               in_frame[ch] = 1'b1;
               frames_started[ch]++;
               bytes_seen[ch] = 0;
               if (gap_chk && ch == 0 && low_valid[ch]) check("gap_low_cycles", low_run[ch], exp_low);
               low_valid[ch] = 1'b0;
            end
            if (!tx_tvalid[ch] && low_valid[ch]) low_run[ch]++;
            if (tx_tvalid[ch] && tready[ch]) begin
               if ((ch == 0 && exp_q0.size() == 0) || (ch == 1 && exp_q1.size() == 0)) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_byte ch%0d: got %0h expected none", ch, cur);
               end else begin
                  exp_b = (ch == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                  check("byte", cur, exp_b);
               end
               bytes_seen[ch]++;
               if (tx_tlast[ch]) begin
                  in_frame[ch]  = 1'b0;
                  frames_done[ch]++;
                  low_valid[ch] = 1'b1;
                  low_run[ch]   = 0;
               end
            end
            prev_stall[ch] = tx_tvalid[ch] & ~tready[ch];
            prev_abort[ch] = abort[ch];
            prev_out[ch]   = cur;
         end
      end
   end

   initial begin
      int cyc, s0, d0;
      for (int c = 0; c < N; c++) begin
         frames_started[c] = 0; frames_done[c] = 0; bytes_seen[c] = 0;
         low_run[c] = 0; model_seq[c] = 32'd0;
      end
      prev_stall = '0; prev_abort = '0; in_frame = '0; low_valid = '0;
      rst = 1'b1; en = '0; abort = '0;
      frame_len = 11'd46; gap = 16'd12; mode = 1'b0; pat = 8'h5A;
      dst_mac = 48'h0102_0304_0506; src_mac = 48'hA1A2_A3A4_A5A6; ethertype = 16'h88B5;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tvalid", tx_tvalid, 2'b00);
      check("rst_tlast", tx_tlast, 2'b00);
      check("rst_tuser", tx_tuser, 2'b00);
      check("rst_tdata", tx_tdata, 16'h0000);
      check("rst_frm_cnt", frm_cnt, 64'h0);
      check("rst_busy", busy, 2'b00);
      rst = 1'b0;

      // Basic: two 60-byte frames on ch0, 13 idle cycles between them, ch1 silent.
      gap_chk = 1'b1; exp_low = 13;
      do_frames(0, 2);
      gap_chk = 1'b0;
      check("ch1_idle_frames", frames_started[1], 0);
      check("ch1_idle_busy", busy[1], 1'b0);

      // Length clamping, including a max-size frame whose payload counter wraps.
      frame_len = 11'd10;   mode = 1'b0; gap = 16'd2; do_frames(0, 1);
      frame_len = 11'd2000; mode = 1'b0; gap = 16'd0; do_frames(0, 1);

      // Backpressure at 30% tready on both channels with random configs.
      rdy_pct = 30;
      for (int i = 0; i < 3; i++) begin rand_cfg(); do_frames(0, 1 + (i % 2)); end
      for (int i = 0; i < 2; i++) begin rand_cfg(); do_frames(1, 1 + i); end
      rdy_pct = 100;

      // Abort on payload byte 20 while stalled: truncated frame, seq reused.
      frame_len = 11'd46; mode = 1'b0; gap = 16'd3;
      push_frame(0, model_seq[0], 38);
      stall_at = 38;
      s0 = frames_started[0]; d0 = frames_done[0]; cyc = 0;
      en[0] = 1'b1;
      while (!(frames_started[0] > s0 && bytes_seen[0] >= 38) && cyc < 20000) begin
         @(posedge clk); #1; cyc++;
      end
      en[0] = 1'b0;
      #1 abort[0] = 1'b1;
      @(posedge clk); #2 abort[0] = 1'b0;
      stall_at = 1 << 30;
      while (frames_done[0] <= d0 && cyc < 20000) begin
         @(posedge clk); #1; cyc++;
      end
      wait_cond_timeout("abort_frame", cyc);
      settle(0);
      frame_len = 11'd46; mode = 1'b1; pat = 8'hC3; gap = 16'd1;
      do_frames(0, 1);

      // Sequence wrap from 0xFFFFFFFE.
      force dut.g_ch[0].u_ch.seq_q = 32'hFFFF_FFFE;
      @(posedge clk); #1;
      release dut.g_ch[0].u_ch.seq_q;
      @(posedge clk); #1;
      check("seq_forced", frm_cnt[31:0], 32'hFFFF_FFFE);
      model_seq[0] = 32'hFFFF_FFFE;
      frame_len = 11'd50; mode = 1'b0; gap = 16'd4;
      do_frames(0, 2);
      do_frames(0, 1);

      // Reset mid-payload, then a fresh frame with seq 0.
      frame_len = 11'd100; mode = 1'b0; gap = 16'd5;
      push_frame(0, model_seq[0], -1);
      s0 = frames_started[0]; cyc = 0;
      en[0] = 1'b1;
      while (!(frames_started[0] > s0 && bytes_seen[0] >= 30) && cyc < 20000) begin
         @(posedge clk); #1; cyc++;
      end
      wait_cond_timeout("reset_setup", cyc);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q0.delete();
      check("rst_mid_tvalid", tx_tvalid, 2'b00);
      check("rst_mid_tlast", tx_tlast, 2'b00);
      check("rst_mid_frm_cnt", frm_cnt, 64'h0);
      model_seq[0] = 32'd0;
      model_seq[1] = 32'd0;
      push_frame(0, 32'd0, -1);
      model_seq[0] = 32'd1;
      run_frames(0, 1);
      settle(0);
      settle(1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/eth_txgen.md
# eth_txgen

Multi-channel Ethernet test-frame generator driving the 8-bit AXI-Stream transmit port of each RGMII MAC instance. It replaces the constant-zero tx tie-off with ETHCOUNT independent generators. Each generator emits a programmable header, a 32-bit sequence number, a patterned payload and a programmable inter-frame gap. It sits in `main` between the register/debug logic and the `eth_mac` instances, clocked from the MAC gtx clock domain.

## Interface
Parameters:
- ETHCOUNT, 1, number of channels (1..8)
- LEN_W, 11, width of payload-length field
- GAP_W, 16, width of inter-frame-gap field

Ports:
- clk, in, 1, single clock (mac_gtx_clk domain); one clock, all logic on its rising edge
- rst, in, 1, synchronous, active-high reset
- en, in, ETHCOUNT, per-channel run enable
- abort, in, ETHCOUNT, per-channel single-cycle abort pulse
- frame_len, in, LEN_W, payload bytes after the ethertype, including the 4 seq bytes; shared
- gap, in, GAP_W, idle cycles after each frame; shared
- dst_mac / src_mac, in, 48 each, header addresses; shared
- ethertype, in, 16, header type field
- mode, in, 1: 0 = incrementing payload, 1 = fixed byte `pat`
- pat, in, 8, fixed payload byte
- tx_tdata, out, ETHCOUNT*8, AXIS data, channel x at [x*8 +: 8]
- tx_tvalid / tx_tlast / tx_tuser, out, ETHCOUNT each
- tx_tready, in, ETHCOUNT
- frm_cnt, out, ETHCOUNT*32, completed-frame count per channel (equals next seq)
- busy, out, ETHCOUNT, channel not in IDLE

## Operation
- Frame byte order: dst_mac MSB first (6), src_mac (6), ethertype MSB first (2), seq MSB first (4), payload (L−4). Total 14+L bytes; the MAC appends the FCS.
- L = frame_len clamped to 46..1500. frame_len, gap, mode, pat and the header fields are latched at IDLE→HDR. Changes mid-frame have no effect.
- Payload, mode 0: byte k = k[7:0], with k starting at 0 for each frame and wrapping 255→0. Mode 1: every byte = pat.
- Per-channel FSM:
  - IDLE → HDR when en[x] = 1.
  - HDR (14 bytes) → SEQ (4) → PAY (L−4); tlast on the final PAY byte.
  - Final handshake → GAP, loading the counter with the latched gap.
  - GAP decrements each cycle; at 0 → IDLE. With gap=0, go directly to IDLE.
- en deasserted mid-frame: the frame completes normally, then the channel stays in IDLE.
- abort[x] while tvalid: the current pending byte is re-marked tlast=1, tuser=1.
  - After its handshake → GAP. Seq is not incremented.
  - abort in IDLE or GAP is ignored.
  - abort coincident with the final byte still sets tuser=1, and seq is not incremented.
- seq/frm_cnt increments on every non-aborted tlast handshake and wraps 0xFFFFFFFF→0.
- tuser = 0 except on an aborted last byte.
- Channels are fully independent; no arbitration.

## Timing
- Reset values: tvalid=0, tlast=0, tuser=0, tdata=0x00, frm_cnt=0, busy=0, FSM=IDLE, all counters 0.
- Outputs are registered. en sampled high in IDLE at edge n gives tvalid=1 with tdata=dst_mac[47:40] after edge n.
- AXIS rules:
  - Once tvalid=1, tdata, tlast and tuser hold until tready=1.
  - tvalid never drops mid-frame except on rst.
  - Next byte presented the cycle after the handshake.
  - Throughput is 1 byte/cycle with tready held high.
- Minimum tvalid-low time between frames is gap+1 cycles (GAP cycles plus one IDLE cycle).
- rst mid-frame: outputs return to reset values on the next edge with no tlast. rst must be asserted together with the MAC tx reset.
- busy is high from HDR entry through the last GAP cycle.

## Structure
- Package eth_txgen_pkg:
  - FSM state enum (IDLE, HDR, SEQ, PAY, GAP)
  - constants HDR_LEN=14, SEQ_LEN=4, MIN_PAY=46, MAX_PAY=1500
- Sub-module eth_txgen_ch: one channel (FSM, byte counter, gap counter, seq register, output register).
- eth_txgen is a generate loop of ETHCOUNT eth_txgen_ch instances with bus slicing.

## Test plan
- Basic frame: ETHCOUNT=2, en=2'b01, frame_len=46, gap=12, tready=1.
  - ch0 emits 60 bytes; byte 14..17 = 00 00 00 00; byte 18 = 0x00; byte 59 = 0x29 with tlast.
  - tvalid low exactly 13 cycles; second frame seq = 00 00 00 01.
  - ch1 stays idle.
- Clamping: frame_len=10 → 60 bytes. frame_len=2000 → 1514 bytes. Mode 0 payload wraps 0xFF→0x00.
- Backpressure: random tready at 30% duty.
  - tdata, tlast and tuser stable while tvalid&!tready.
  - Byte sequence identical to the tready=1 run.
- Abort: abort pulse during payload byte 20 with tready=0.
  - The pending byte goes out with tlast=1 and tuser=1.
  - frm_cnt unchanged; the next frame reuses the same seq.
- Enable and counter wrap:
  - en dropped at header byte 3: the frame completes in full, then no further tvalid.
  - frm_cnt forced near 0xFFFFFFFF wraps to 0.
- Reset: rst mid-payload → next cycle tvalid=0, frm_cnt=0. After release with en=1, a fresh frame starts with seq 0.
